axil_byte_ram: RTL and testbench
================================

AXIL_BYTE_RAM -- requirements
Module: axil_byte_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits (32 or 64 only).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning byte-address width.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, meaning implemented word count (≤ 2^(ADDR_WIDTH-log2(DATA_WIDTH/8))).
REQ-004 SHALL use clock ACLK and reset ARESETN, synchronous, active-low.
REQ-005 Ports: ACLK in 1 clock; ARESETN in 1 sync active-low reset.
REQ-006 Ports: AWADDR in ADDR_WIDTH; AWVALID in 1; AWREADY out 1 (write-address channel).
REQ-007 Ports: WDATA in DATA_WIDTH; WSTRB in DATA_WIDTH/8; WVALID in 1; WREADY out 1 (write-data channel).
REQ-008 Ports: BRESP out 2; BVALID out 1; BREADY in 1 (write-response channel).
REQ-009 Ports: ARADDR in ADDR_WIDTH; ARVALID in 1; ARREADY out 1 (read-address channel).
REQ-010 Ports: RDATA out DATA_WIDTH; RRESP out 2; RVALID out 1; RREADY in 1 (read-data channel).

Function
REQ-011 Word index SHALL be the address shifted right by log2(DATA_WIDTH/8); low address bits SHALL be ignored.
REQ-012 AW and W SHALL be accepted independently, each into a one-entry holding register; a transfer occurs only when VALID and READY are both high on a rising edge.
REQ-013 AWREADY SHALL be high when the AW holding register is empty; WREADY SHALL be high when the W holding register is empty.
REQ-014 Write SHALL commit in the cycle after both holding registers are full and BVALID is low; both registers SHALL be freed in the same edge that asserts BVALID.
REQ-015 Only byte lanes with WSTRB[i]=1 SHALL be updated; WSTRB=0 SHALL complete with OKAY and no memory change.
REQ-016 Word index ≥ MEM_WORDS SHALL not modify memory and SHALL return BRESP=2'b10 (SLVERR); in-range writes SHALL return 2'b00.
REQ-017 BVALID/BRESP SHALL hold stable until BREADY is sampled high; the next write SHALL not commit while BVALID is high.
REQ-018 ARREADY SHALL be high when RVALID is low and no read is in flight; an accepted read SHALL assert RVALID exactly one cycle after the AR handshake.
REQ-019 Out-of-range reads SHALL return RDATA=0, RRESP=2'b10; in-range reads SHALL return RRESP=2'b00.
REQ-020 RVALID/RDATA/RRESP SHALL hold stable until RREADY is sampled high; ARREADY SHALL be low while RVALID is high.
REQ-021 Read and write commit to the same word in the same cycle SHALL return the old (pre-write) data.
REQ-022 Read and write paths SHALL operate concurrently with no mutual stall.
REQ-023 Maximum write throughput SHALL be one write per two cycles with BREADY held high; maximum read throughput SHALL be one read per two cycles with RREADY held high.

Reset
REQ-024 On ARESETN low at a rising edge: AWREADY, WREADY, BVALID, ARREADY, RVALID SHALL be 0; BRESP, RRESP, RDATA SHALL be 0; holding registers SHALL be emptied.
REQ-025 Memory contents SHALL not be reset; a write in its holding registers when reset is asserted SHALL be discarded.
REQ-026 AWREADY, WREADY and ARREADY SHALL assert in the first cycle after ARESETN returns high.

Structure
REQ-027 Package axil_pkg SHALL hold RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, plus the AXI-Lite response typedef.
REQ-028 Storage SHALL be a sub-module axil_ram_core: one byte-enabled write port and one synchronous read port with read-before-write.

Verification
REQ-029 Reset, then AW 0x010 and W 0xDEADBEEF/STRB 0xF in the same cycle, then AR 0x010 -> BRESP=00, RDATA=0xDEADBEEF, RRESP=00.
REQ-030 W presented 3 cycles before AW at 0x020 (data 0x11223344, STRB 0x5 over prior 0xFFFFFFFF) -> single B OKAY; readback 0xFF22FF44.
REQ-031 AW 0x1000 with MEM_WORDS=1024 -> BRESP=10, memory unchanged; AR 0x1000 -> RDATA=0, RRESP=10.
REQ-032 BREADY held low 5 cycles after write -> BVALID and BRESP stable; a second AW/W pair is accepted but not committed until B completes.
REQ-033 RREADY held low 4 cycles -> RVALID/RDATA stable, ARREADY low; simultaneous write and read to 0x040 -> old data returned.
REQ-034 ARESETN pulsed low with AW accepted and W pending -> all VALIDs 0 next cycle; the following read of that address shows no write.

Source files
------------

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// axil_pkg : AXI-Lite response codes shared by the byte-RAM slice
// Revision : 1.0
// ============================================================================
package axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  function automatic axil_resp_t range_resp(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_ram_core.sv
`default_nettype none
// ============================================================================
// axil_ram_core : byte-enabled write port, registered read-before-write port
// Revision : 1.0
// ============================================================================
module axil_ram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int ADDR_BITS  = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ADDR_BITS-1:0]    wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_BITS-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Both ports share one edge; the read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (wr_strb[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axil_byte_ram.sv
`default_nettype none
// ============================================================================
// axil_byte_ram : AXI-Lite slave wrapping a byte-enabled single-cycle RAM
// Revision : 1.0
// ============================================================================
module axil_byte_ram
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF;
  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [IDX_W:0] MEM_LIMIT = MEM_WORDS[IDX_W:0];

  logic                  accepting;
  logic                  aw_full;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic [IDX_W-1:0] aw_idx_in;
  logic [IDX_W-1:0] ar_idx_in;
  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;
  logic             aw_ok;
  logic             ar_ok;
  logic             unused_addr_bits;

  assign aw_idx_in = AWADDR[ADDR_WIDTH-1:OFF];
  assign ar_idx_in = ARADDR[ADDR_WIDTH-1:OFF];
  assign unused_addr_bits = ^{AWADDR[OFF-1:0], ARADDR[OFF-1:0]};

  // accepting is low during reset and rises on the first edge after release.
  assign AWREADY = accepting & ~aw_full;
  assign WREADY  = accepting & ~w_full;
  assign ARREADY = accepting & ~RVALID;

  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign ar_hs  = ARVALID & ARREADY;
  assign commit = aw_full & w_full & ~BVALID;

  assign aw_ok = ({1'b0, aw_idx} < MEM_LIMIT);
  assign ar_ok = ({1'b0, ar_idx_in} < MEM_LIMIT);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      accepting <= 1'b0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      RVALID    <= 1'b0;
      RRESP     <= RESP_OKAY;
      rd_ok     <= 1'b0;
    end else begin
      accepting <= 1'b1;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= aw_idx_in;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      // Holding registers free on the same edge that raises BVALID.
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        BVALID  <= 1'b1;
        BRESP   <= range_resp(aw_ok);
      end else if (BVALID && BREADY) begin
        BVALID <= 1'b0;
      end
      if (ar_hs) begin
        RVALID <= 1'b1;
        RRESP  <= range_resp(ar_ok);
        rd_ok  <= ar_ok;
      end else if (RVALID && RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

  // Core read register only loads on an AR handshake, so it holds while RVALID waits.
  assign RDATA = (RVALID && rd_ok) ? core_rdata : '0;

  axil_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .ADDR_BITS  (MEM_AW)
  ) u_core (
    .clk     (ACLK),
    .wr_en   (commit & aw_ok),
    .wr_addr (aw_idx[MEM_AW-1:0]),
    .wr_strb (w_strb),
    .wr_data (w_data),
    .rd_en   (ar_hs),
    .rd_addr (ar_idx_in[MEM_AW-1:0]),
    .rd_data (core_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_axil_byte_ram.sv
`default_nettype none
// ============================================================================
// tb_axil_byte_ram : directed vectors and corner sequences for axil_byte_ram
// Revision : 1.0
// ============================================================================
module tb_axil_byte_ram;
  import axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int MW = 1024;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] AWADDR = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic [AW-1:0] ARADDR = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axil_byte_ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_WORDS  (MW)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
    logic [1:0]    bresp;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, aw_now, w_now;
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    BREADY = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (aw_done && w_done) break;
      aw_now = AWREADY && AWVALID;
      w_now  = WREADY && WVALID;
      tick();
      if (aw_now) begin aw_done = 1'b1; AWVALID = 1'b0; end
      if (w_now)  begin w_done = 1'b1;  WVALID = 1'b0;  end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check("wr_handshake", {62'd0, aw_done, w_done}, 64'd3);
    for (int c = 0; c < 20; c++) begin
      if (BVALID) break;
      tick();
    end
    check("wr_bvalid", BVALID, 1);
    resp = BRESP;
    tick();
  endtask

  task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                         output logic [1:0] resp);
    logic done, now;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      now = ARREADY;
      tick();
      if (now) begin done = 1'b1; ARVALID = 1'b0; end
    end
    ARVALID = 1'b0;
    check("rd_handshake", done, 1);
    check("rd_rvalid_latency", RVALID, 1);
    data = RDATA;
    resp = RRESP;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]    resp;
    logic [1:0]    rresp;
    logic [DW-1:0] rdata;
    int            b_count;

    vecs[0] = '{16'h0000, 32'h55AA55AA, 4'hF, RESP_OKAY,   32'h55AA55AA, RESP_OKAY};
    vecs[1] = '{16'h0010, 32'hDEADBEEF, 4'hF, RESP_OKAY,   32'hDEADBEEF, RESP_OKAY};
    vecs[2] = '{16'h0030, 32'hA5A5A5A5, 4'hF, RESP_OKAY,   32'hA5A5A5A5, RESP_OKAY};
    vecs[3] = '{16'h0031, 32'h00000000, 4'h0, RESP_OKAY,   32'hA5A5A5A5, RESP_OKAY};
    vecs[4] = '{16'h0032, 32'h12345678, 4'h8, RESP_OKAY,   32'h12A5A5A5, RESP_OKAY};
    vecs[5] = '{16'h0033, 32'h9ABCDEF0, 4'h3, RESP_OKAY,   32'h12A5DEF0, RESP_OKAY};
    vecs[6] = '{16'h1000, 32'hCAFEF00D, 4'hF, RESP_SLVERR, 32'h00000000, RESP_SLVERR};
    vecs[7] = '{16'h0FFC, 32'h01020304, 4'hF, RESP_OKAY,   32'h01020304, RESP_OKAY};
    vecs[8] = '{16'h1004, 32'h11111111, 4'hF, RESP_SLVERR, 32'h00000000, RESP_SLVERR};
    vecs[9] = '{16'hFFFC, 32'h22222222, 4'hF, RESP_SLVERR, 32'h00000000, RESP_SLVERR};

    // Reset state
    tick(); tick(); tick();
    check("rst_awready", AWREADY, 0);
    check("rst_wready",  WREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_bvalid",  BVALID, 0);
    check("rst_rvalid",  RVALID, 0);
    check("rst_bresp",   BRESP, 0);
    check("rst_rresp",   RRESP, 0);
    check("rst_rdata",   RDATA, 0);
    ARESETN = 1'b1;
    tick();
    check("rel_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);

    // Vector table: write then read back each entry
    for (int i = 0; i < 10; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
      check($sformatf("vec%0d_bresp", i), resp, vecs[i].bresp);
      do_read(vecs[i].addr, rdata, rresp);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
      check($sformatf("vec%0d_rresp", i), rresp, vecs[i].rresp);
    end
    do_read(16'h0000, rdata, rresp);
    check("oor_no_alias", rdata, 32'h55AA55AA);

    // W arrives three cycles ahead of AW
    do_write(16'h0020, 32'hFFFFFFFF, 4'hF, resp);
    BREADY = 1'b1;
    WDATA = 32'h11223344; WSTRB = 4'h5; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    check("early_w_held", WREADY, 0);
    tick(); tick();
    check("early_w_no_b", BVALID, 0);
    AWADDR = 16'h0020; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    b_count = 0;
    for (int i = 0; i < 4; i++) begin
      if (BVALID) begin
        b_count++;
        check("early_w_bresp", BRESP, RESP_OKAY);
      end
      tick();
    end
    check("early_w_b_count", b_count, 1);
    do_read(16'h0020, rdata, rresp);
    check("early_w_rdata", rdata, 32'hFF22FF44);

    // B backpressure with a second write queued behind it
    do_write(16'h0054, 32'h77777777, 4'hF, resp);
    BREADY = 1'b0;
    AWADDR = 16'h0050; AWVALID = 1'b1; WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    check("bp_bvalid", BVALID, 1);
    check("bp_bresp", BRESP, RESP_OKAY);
    AWADDR = 16'h0054; AWVALID = 1'b1; WDATA = 32'h600DCAFE; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_valid", BVALID, 1);
      check("bp_hold_resp", BRESP, RESP_OKAY);
      check("bp_hold_full", {62'd0, AWREADY, WREADY}, 64'd0);
      tick();
    end
    do_read(16'h0054, rdata, rresp);
    check("bp_not_committed", rdata, 32'h77777777);
    check("bp_still_valid", BVALID, 1);
    BREADY = 1'b1;
    tick();
    check("bp_first_done", BVALID, 0);
    tick();
    check("bp_second_b", BVALID, 1);
    check("bp_second_resp", BRESP, RESP_OKAY);
    tick();
    do_read(16'h0054, rdata, rresp);
    check("bp_second_data", rdata, 32'h600DCAFE);
    do_read(16'h0050, rdata, rresp);
    check("bp_first_data", rdata, 32'h0BADF00D);

    // R backpressure
    do_write(16'h0060, 32'h13572468, 4'hF, resp);
    RREADY = 1'b0;
    ARADDR = 16'h0060; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rbp_rvalid", RVALID, 1);
      check("rbp_rdata", RDATA, 32'h13572468);
      check("rbp_arready", ARREADY, 0);
      tick();
    end
    RREADY = 1'b1;
    tick();
    check("rbp_released", RVALID, 0);

    // Same-edge write commit and read of one word returns old data
    do_write(16'h0040, 32'hAAAA0000, 4'hF, resp);
    BREADY = 1'b1; RREADY = 1'b1;
    AWADDR = 16'h0040; AWVALID = 1'b1; WDATA = 32'h0000BBBB; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 16'h0040; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    check("rbw_bvalid", BVALID, 1);
    check("rbw_rvalid", RVALID, 1);
    check("rbw_old_data", RDATA, 32'hAAAA0000);
    tick();
    do_read(16'h0040, rdata, rresp);
    check("rbw_new_data", rdata, 32'h0000BBBB);

    // Reset with AW held and W pending discards the write
    do_write(16'h0070, 32'h24682468, 4'hF, resp);
    AWADDR = 16'h0070; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("mrst_aw_held", AWREADY, 0);
    WDATA = 32'hDEADDEAD; WSTRB = 4'hF; WVALID = 1'b1;
    ARESETN = 1'b0;
    tick();
    check("mrst_valids", {62'd0, BVALID, RVALID}, 64'd0);
    check("mrst_readys", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
    WVALID = 1'b0;
    ARESETN = 1'b1;
    tick();
    check("mrst_ready_back", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);
    tick();
    check("mrst_no_b", BVALID, 0);
    do_read(16'h0070, rdata, rresp);
    check("mrst_no_write", rdata, 32'h24682468);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
